// File: rtl/dtcm_pkg.sv
// Shared constants and types for the dual-channel data TCM.
package dtcm_pkg;

    localparam int ARB_FIXED  = 0;
    localparam int ARB_RR     = 1;

    localparam logic CH_CORE  = 1'b0;
    localparam logic CH_LOAD  = 1'b1;

    localparam int WORD_BYTES = 4;

    // Tag carried alongside each granted access until its response is emitted.
    typedef struct packed {
        logic vld;
        logic ch;
        logic err;
        logic wr;
    } resp_tag_t;

    // Number of word-index bits needed to address depth_words words.
    function automatic int idx_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/dtcm_ram.sv
// Single-port byte-writable synchronous RAM, behavioural so a vendor macro can replace it.
module dtcm_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          ce,
    input  logic [3:0]    wen,
    input  logic [AW-1:0] ad,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    logic [31:0] mem [DEPTH];

    // Byte-masked write and read-before-write output on every enabled cycle.
    always_ff @(posedge clk) begin
        if (ce) begin
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) begin
                    mem[ad][8*i +: 8] <= din[8*i +: 8];
                end
            end
            dout <= mem[ad];
        end
    end

endmodule

// File: rtl/dtcm_arb.sv
// Data TCM with core and loader channels arbitrated onto one single-port RAM.
module dtcm_arb
    import dtcm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int READ_LAT    = 1,
    parameter int ARB_MODE    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic [31:0] c_addr,
    input  logic [3:0]  c_wen,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        c_err,
    input  logic        l_req,
    input  logic [31:0] l_addr,
    input  logic [3:0]  l_wen,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_rdata,
    output logic        l_err
);

    localparam int IW = idx_width(DEPTH_WORDS);

    logic        ptr_q, ptr_d;
    logic        any_gnt;
    logic        sel_ch;
    logic [31:0] sel_addr;
    logic [3:0]  sel_wen;
    logic [31:0] sel_wdata;
    logic        sel_oor;
    logic        ram_ce;
    logic [3:0]  ram_wen;
    logic [31:0] ram_dout;
    resp_tag_t   s1_d, s1_q;
    logic [31:0] s1_data;
    resp_tag_t   out_tag;
    logic [31:0] out_data;
    logic [31:0] c_hold_d, c_hold_q;
    logic [31:0] l_hold_d, l_hold_q;

    // Grant decode and round-robin pointer update; pointer only moves on a conflict.
    always_comb begin
        c_gnt = 1'b0;
        l_gnt = 1'b0;
        ptr_d = ptr_q;
        if (ARB_MODE == ARB_RR && c_req && l_req) begin
            if (ptr_q == CH_CORE) begin
                c_gnt = 1'b1;
            end else begin
                l_gnt = 1'b1;
            end
            ptr_d = ~ptr_q;
        end else begin
            c_gnt = c_req;
            l_gnt = l_req & ~c_req;
        end
    end

    // Steer the winning channel's payload onto the RAM port and range-check it.
    always_comb begin
        any_gnt   = c_gnt | l_gnt;
        sel_ch    = l_gnt ? CH_LOAD : CH_CORE;
        sel_addr  = l_gnt ? l_addr  : c_addr;
        sel_wen   = l_gnt ? l_wen   : c_wen;
        sel_wdata = l_gnt ? l_wdata : c_wdata;
        sel_oor   = |sel_addr[31:IW+2];
        ram_ce    = any_gnt & ~sel_oor;
        ram_wen   = ram_ce ? sel_wen : 4'h0;
        s1_d.vld  = any_gnt;
        s1_d.ch   = sel_ch;
        s1_d.err  = sel_oor;
        s1_d.wr   = |sel_wen;
    end

    dtcm_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (IW)
    ) u_ram (
        .clk  (clk),
        .ce   (ram_ce),
        .wen  (ram_wen),
        .ad   (sel_addr[IW+1:2]),
        .din  (sel_wdata),
        .dout (ram_dout)
    );

    // Arbitration pointer and first response stage (lines up with RAM output).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= CH_CORE;
            s1_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            s1_q  <= s1_d;
        end
    end

    // Writes and out-of-range accesses return zero data.
    assign s1_data = (s1_q.err | s1_q.wr) ? 32'h0 : ram_dout;

    if (READ_LAT >= 2) begin : g_lat2
        resp_tag_t   s2_q;
        logic [31:0] s2_data_q;

        // Extra output register stage for the two-cycle latency option.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s2_q      <= '0;
                s2_data_q <= 32'h0;
            end else begin
                s2_q      <= s1_q;
                s2_data_q <= s1_data;
            end
        end

        assign out_tag  = s2_q;
        assign out_data = s2_data_q;
    end else begin : g_lat1
        assign out_tag  = s1_q;
        assign out_data = s1_data;
    end

    // Route the response to its owning channel; rdata holds between responses.
    always_comb begin
        c_rvalid = out_tag.vld & (out_tag.ch == CH_CORE);
        l_rvalid = out_tag.vld & (out_tag.ch == CH_LOAD);
        c_err    = c_rvalid & out_tag.err;
        l_err    = l_rvalid & out_tag.err;
        c_rdata  = c_rvalid ? out_data : c_hold_q;
        l_rdata  = l_rvalid ? out_data : l_hold_q;
        c_hold_d = c_rdata;
        l_hold_d = l_rdata;
    end

    // Last delivered read data per channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_hold_q <= 32'h0;
            l_hold_q <= 32'h0;
        end else begin
            c_hold_q <= c_hold_d;
            l_hold_q <= l_hold_d;
        end
    end

endmodule

// File: tb/tb_dtcm_arb.sv
// Self-checking bench: three dtcm_arb variants (RR/lat1, fixed/lat1, RR/lat2) share stimulus,
// each scored against its own reference model and response queue.
module tb_dtcm_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, l_req;
    logic [31:0] c_addr, l_addr, c_wdata, l_wdata;
    logic [3:0]  c_wen, l_wen;

    logic [2:0]  c_gnt_w, l_gnt_w, c_rvalid_w, l_rvalid_w, c_err_w, l_err_w;
    logic [31:0] c_rdata_w [3];
    logic [31:0] l_rdata_w [3];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct packed {
        logic        ch;
        logic        err;
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;

    exp_t        sb_q [3][$];
    logic [31:0] mdl_mem [3][1024];
    logic        mdl_ptr [3];
    logic [31:0] last_c [3];
    logic [31:0] last_l [3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        dtcm_arb #(
            .DEPTH_WORDS (1024),
            .READ_LAT    (k == 2 ? 2 : 1),
            .ARB_MODE    (k == 1 ? 0 : 1)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .c_req    (c_req),
            .c_addr   (c_addr),
            .c_wen    (c_wen),
            .c_wdata  (c_wdata),
            .c_gnt    (c_gnt_w[k]),
            .c_rvalid (c_rvalid_w[k]),
            .c_rdata  (c_rdata_w[k]),
            .c_err    (c_err_w[k]),
            .l_req    (l_req),
            .l_addr   (l_addr),
            .l_wen    (l_wen),
            .l_wdata  (l_wdata),
            .l_gnt    (l_gnt_w[k]),
            .l_rvalid (l_rvalid_w[k]),
            .l_rdata  (l_rdata_w[k]),
            .l_err    (l_err_w[k])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected response of one granted access, applying writes to the model memory.
    task automatic model_access(input int k, input logic ch, input logic [31:0] addr,
                                input logic [3:0] wen, input logic [31:0] wdata);
        exp_t e;
        e.ch   = ch;
        e.err  = (addr >= 32'h1000);
        e.data = 32'h0;
        e.due  = cyc + ((k == 2) ? 2 : 1);
        if (!e.err) begin
            if (wen != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (wen[b]) mdl_mem[k][addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                e.data = mdl_mem[k][addr[11:2]];
            end
        end
        sb_q[k].push_back(e);
    endtask

    task automatic model_cycle(input int k);
        exp_t e;
        logic exp_cv, exp_lv, exp_ce, exp_le, eg_c, eg_l, rr;
        if (reset) begin
            sb_q[k].delete();
            mdl_ptr[k] = 1'b0;
            last_c[k]  = 32'h0;
            last_l[k]  = 32'h0;
            chk($sformatf("u%0d rst c_rvalid", k), {31'h0, c_rvalid_w[k]}, 32'h0);
            chk($sformatf("u%0d rst l_rvalid", k), {31'h0, l_rvalid_w[k]}, 32'h0);
            chk($sformatf("u%0d rst c_rdata", k), c_rdata_w[k], 32'h0);
            chk($sformatf("u%0d rst l_rdata", k), l_rdata_w[k], 32'h0);
            return;
        end
        exp_cv = 1'b0; exp_lv = 1'b0; exp_ce = 1'b0; exp_le = 1'b0;
        if (sb_q[k].size() > 0 && sb_q[k][0].due == cyc) begin
            e = sb_q[k].pop_front();
            if (e.ch == 1'b0) begin
                exp_cv = 1'b1; exp_ce = e.err; last_c[k] = e.data;
            end else begin
                exp_lv = 1'b1; exp_le = e.err; last_l[k] = e.data;
            end
        end
        chk($sformatf("u%0d c_rvalid", k), {31'h0, c_rvalid_w[k]}, {31'h0, exp_cv});
        chk($sformatf("u%0d l_rvalid", k), {31'h0, l_rvalid_w[k]}, {31'h0, exp_lv});
        chk($sformatf("u%0d c_rdata", k), c_rdata_w[k], last_c[k]);
        chk($sformatf("u%0d l_rdata", k), l_rdata_w[k], last_l[k]);
        if (exp_cv) chk($sformatf("u%0d c_err", k), {31'h0, c_err_w[k]}, {31'h0, exp_ce});
        if (exp_lv) chk($sformatf("u%0d l_err", k), {31'h0, l_err_w[k]}, {31'h0, exp_le});

        rr   = (k != 1);
        eg_c = c_req && (!l_req || !rr || mdl_ptr[k] == 1'b0);
        eg_l = l_req && !eg_c;
        chk($sformatf("u%0d c_gnt", k), {31'h0, c_gnt_w[k]}, {31'h0, eg_c});
        chk($sformatf("u%0d l_gnt", k), {31'h0, l_gnt_w[k]}, {31'h0, eg_l});
        if (rr && c_req && l_req) mdl_ptr[k] = ~mdl_ptr[k];
        if (eg_c) model_access(k, 1'b0, c_addr, c_wen, c_wdata);
        if (eg_l) model_access(k, 1'b1, l_addr, l_wen, l_wdata);
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) model_cycle(k);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cr, input logic [31:0] ca, input logic [3:0] cw,
                         input logic [31:0] cd, input logic lr, input logic [31:0] la,
                         input logic [3:0] lw, input logic [31:0] ld);
        c_req = cr; c_addr = ca; c_wen = cw; c_wdata = cd;
        l_req = lr; l_addr = la; l_wen = lw; l_wdata = ld;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Preload words 0..15 through the loader.
        for (int w = 0; w < 16; w++) begin
            drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'(w * 4), 4'hF, 32'hA000_0000 + 32'(w));
            tick();
        end

        // Loader write then core read of the same word.
        drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h10, 4'hF, 32'h1122_3344);
        tick();
        drive(1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("t1 c_gnt", {31'h0, c_gnt_w[0]}, 32'h1);
        tick();
        idle();
        @(negedge clk);
        chk("t1 c_rvalid", {31'h0, c_rvalid_w[0]}, 32'h1);
        chk("t1 c_rdata", c_rdata_w[0], 32'h1122_3344);
        chk("t1 c_err", {31'h0, c_err_w[0]}, 32'h0);
        tick();

        // Single byte-lane write.
        drive(1'b1, 32'h10, 4'h4, 32'h00AB_0000, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        drive(1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("t2 c_rdata", c_rdata_w[0], 32'h11AB_3344);
        tick();

        // Both channels request for four cycles.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0, 4'h0, 32'h0, 1'b1, 32'h4, 4'h0, 32'h0);
            @(negedge clk);
            chk("t3 rr gnt", {30'h0, c_gnt_w[0], l_gnt_w[0]}, (i % 2 == 0) ? 32'h2 : 32'h1);
            chk("t3 fixed gnt", {30'h0, c_gnt_w[1], l_gnt_w[1]}, 32'h2);
            tick();
        end
        drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h4, 4'h0, 32'h0);
        @(negedge clk);
        chk("t3 fixed l_gnt", {31'h0, l_gnt_w[1]}, 32'h1);
        tick();
        idle();
        tick();

        // Out-of-range read and write.
        drive(1'b1, 32'h1000, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("t4 c_err", {31'h0, c_err_w[0]}, 32'h1);
        chk("t4 c_rdata", c_rdata_w[0], 32'h0);
        tick();
        drive(1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        drive(1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("t4 word0", c_rdata_w[0], 32'hA000_0000);
        tick();

        // Back-to-back reads; two-cycle variant keeps two in flight.
        drive(1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        drive(1'b1, 32'h4, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        drive(1'b1, 32'h8, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("t5 lat2 rdata1", c_rdata_w[2], 32'hA000_0001);
        tick();
        @(negedge clk);
        chk("t5 lat2 rdata2", c_rdata_w[2], 32'hA000_0002);
        tick();

        // Move the pointer to loader, put reads in flight, then reset.
        drive(1'b1, 32'h0, 4'h0, 32'h0, 1'b1, 32'h4, 4'h0, 32'h0);
        tick();
        drive(1'b1, 32'h8, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        drive(1'b1, 32'hC, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("t6 rvalid in reset", {29'h0, c_rvalid_w}, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6 no late rvalid", {29'h0, c_rvalid_w | l_rvalid_w}, 32'h0);
        chk("t6 rdata zero", c_rdata_w[2], 32'h0);
        tick();
        drive(1'b1, 32'h0, 4'h0, 32'h0, 1'b1, 32'h4, 4'h0, 32'h0);
        @(negedge clk);
        chk("t6 rr gnt core", {30'h0, c_gnt_w[0], l_gnt_w[0]}, 32'h2);
        chk("t6 rr2 gnt core", {30'h0, c_gnt_w[2], l_gnt_w[2]}, 32'h2);
        tick();

        // Random traffic on both channels, mixed reads, partial writes, out-of-range.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a0, a1;
            a0 = ($urandom_range(0, 9) == 0) ? 32'h1000 + 32'($urandom_range(0, 3) * 4)
                                             : 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            a1 = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                                             : 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            drive(1'($urandom_range(0, 1)), a0,
                  $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15)), $urandom(),
                  1'($urandom_range(0, 1)), a1,
                  $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15)), $urandom());
            tick();
        end
        idle();
        repeat (5) tick();
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("u%0d drained", k), 32'(sb_q[k].size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
